// File: rtl/div241_seq_if.sv
// Handshake bundle for the divide-by-241 engine: dividend in, quotient/remainder out.
// The master side offers dividends and consumes results; the slave side is the engine.
interface div241_seq_if #(
  parameter int W = 36,
  parameter int R = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_dividend;
  logic         abort;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_quotient;
  logic [R-1:0] out_remainder;
  logic         busy;

  modport master (
    output in_valid, in_dividend, abort, out_ready,
    input  in_ready, out_valid, out_quotient, out_remainder, busy
  );

  modport slave (
    input  in_valid, in_dividend, abort, out_ready,
    output in_ready, out_valid, out_quotient, out_remainder, busy
  );
endinterface

// File: rtl/div241_seq.sv
// Sequential divide-by-241: one radix-8 digit per cycle, result 12 cycles after acceptance.
// Single operation in flight; in_ready only in IDLE, result held until out_ready or abort.

module div241_step #(
  parameter int R = 8,
  parameter int D = 3,
  parameter int M = 241
) (
  input  logic [R-1:0] r,
  input  logic [D-1:0] c,
  output logic [D-1:0] q,
  output logic [R-1:0] rn
);
  logic [R+D-1:0] v;
  logic [R+D-1:0] sub;

  // r < M guarantees v < M*2^D, so the digit is the count of multiples of M not above v
  always_comb begin
    v   = {r, c};
    q   = '0;
    sub = '0;
    for (int k = 1; k < (1 << D); k++) begin
      if (v >= (R+D)'(M * k)) begin
        q   = D'(k);
        sub = (R+D)'(M * k);
      end
    end
    rn = R'(v - sub);
  end
endmodule

module div241_seq #(
  parameter int W = 36,
  parameter int D = 3,
  parameter int R = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  div241_seq_if.slave bus
);
  localparam int N  = W / D;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_n;
  logic [W-1:0]  sr;
  logic [R-1:0]  rem;
  logic [CW-1:0] cnt;
  logic          load, step;
  logic [D-1:0]  qd;
  logic [R-1:0]  rn;

  div241_step #(.R(R), .D(D), .M(241)) u_step (
    .r  (rem),
    .c  (sr[W-1:W-D]),
    .q  (qd),
    .rn (rn)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // abort outranks both acceptance and stepping in every state
  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid && !bus.abort) begin
          load    = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_n = IDLE;
        end else begin
          step = 1'b1;
          if (cnt == LAST) state_n = DONE;
        end
      end
      DONE: begin
        if (bus.abort || bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // quotient digits enter at the LSB while dividend digits leave the MSB
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr  <= '0;
      rem <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= bus.in_dividend;
      rem <= '0;
      cnt <= '0;
    end else if (step) begin
      sr  <= {sr[W-D-1:0], qd};
      rem <= rn;
      cnt <= cnt + 1'b1;
    end
  end

  assign bus.in_ready      = (state == IDLE);
  assign bus.out_valid     = (state == DONE);
  assign bus.busy          = (state != IDLE);
  assign bus.out_quotient  = sr;
  assign bus.out_remainder = rem;
endmodule

// File: tb/tb_div241_seq.sv
// Bench for div241_seq: directed vector table, abort/reset sequences, random golden-model sweep.
module tb_div241_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  div241_seq_if bus ();

  div241_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [35:0] x;
    logic [35:0] q;
    logic [7:0]  r;
    int          hold;
    bit          tied;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [35:0] x, input int hold, input bit tied,
                        output logic [35:0] q, output logic [7:0] r, output int acc_cyc);
    int w;
    int lat;
    bit ok;
    logic [35:0] q0;
    logic [7:0]  r0;
    bus.in_valid    = 1'b1;
    bus.in_dividend = x;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      tick;
      w++;
    end
    if (!bus.in_ready) chk("accept_timeout", 0, 1);
    acc_cyc = cyc;
    tick;
    bus.in_valid    = 1'b0;
    bus.in_dividend = '0;
    lat = 0;
    ok  = 1'b1;
    while (!bus.out_valid && lat < 40) begin
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) ok = 1'b0;
      tick;
      lat++;
    end
    chk("run_flags", 64'(ok), 1);
    chk("latency", 64'(lat), 12);
    q0 = bus.out_quotient;
    r0 = bus.out_remainder;
    if (!tied) begin
      ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
        tick;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
            bus.out_quotient !== q0 || bus.out_remainder !== r0) ok = 1'b0;
      end
      if (hold > 0) chk("hold_stable", 64'(ok), 1);
      bus.out_ready = 1'b1;
    end
    tick;
    if (!tied) bus.out_ready = 1'b0;
    chk("post_hs_in_ready", 64'(bus.in_ready), 1);
    chk("post_hs_out_valid", 64'(bus.out_valid), 0);
    q = q0;
    r = r0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [35:0] q;
    logic [7:0]  r;
    logic [35:0] x;
    int acc, prev_acc;
    bit saw;

    vecs[0] = '{36'd0,           36'd0,         8'd0,   0, 1'b0};
    vecs[1] = '{36'd240,         36'd0,         8'd240, 0, 1'b1};
    vecs[2] = '{36'd241,         36'd1,         8'd0,   0, 1'b1};
    vecs[3] = '{36'hFFFFFFFFF,   36'd285143056, 8'd239, 0, 1'b1};
    vecs[4] = '{36'd1000000007,  36'd4149377,   8'd150, 5, 1'b0};
    vecs[5] = '{36'd1,           36'd0,         8'd1,   1, 1'b0};
    vecs[6] = '{36'd242,         36'd1,         8'd1,   0, 1'b0};
    vecs[7] = '{36'd58081,       36'd241,       8'd0,   2, 1'b0};
    vecs[8] = '{36'd1927,        36'd7,         8'd240, 0, 1'b0};
    vecs[9] = '{36'h800000000,   36'd142571528, 8'd120, 3, 1'b0};

    bus.in_valid    = 1'b0;
    bus.in_dividend = '0;
    bus.abort       = 1'b0;
    bus.out_ready   = 1'b0;
    rst_n           = 1'b0;
    tick;
    tick;
    chk("rst_in_ready",  64'(bus.in_ready), 1);
    chk("rst_out_valid", 64'(bus.out_valid), 0);
    chk("rst_busy",      64'(bus.busy), 0);
    chk("rst_quotient",  64'(bus.out_quotient), 0);
    chk("rst_remainder", 64'(bus.out_remainder), 0);
    rst_n = 1'b1;
    tick;

    prev_acc = 0;
    for (int i = 0; i < 10; i++) begin
      bus.out_ready = vecs[i].tied;
      run_op(vecs[i].x, vecs[i].hold, vecs[i].tied, q, r, acc);
      chk($sformatf("vec%0d_quotient", i), 64'(q), 64'(vecs[i].q));
      chk($sformatf("vec%0d_remainder", i), 64'(r), 64'(vecs[i].r));
      if (i > 0 && vecs[i].tied && vecs[i-1].tied)
        chk($sformatf("vec%0d_accept_spacing", i), 64'(acc - prev_acc), 14);
      prev_acc = acc;
    end
    bus.out_ready = 1'b0;

    // abort in the sixth RUN cycle discards the operation
    bus.in_valid    = 1'b1;
    bus.in_dividend = 36'd1000;
    tick;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick;
    chk("pre_abort_busy", 64'(bus.busy), 1);
    bus.abort = 1'b1;
    tick;
    bus.abort = 1'b0;
    chk("abort_in_ready",  64'(bus.in_ready), 1);
    chk("abort_busy",      64'(bus.busy), 0);
    chk("abort_out_valid", 64'(bus.out_valid), 0);
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (bus.out_valid !== 1'b0) saw = 1'b1;
    end
    chk("abort_no_result", 64'(saw), 0);
    run_op(36'd482, 0, 1'b0, q, r, acc);
    chk("after_abort_quotient",  64'(q), 2);
    chk("after_abort_remainder", 64'(r), 0);

    // abort in IDLE blocks acceptance
    bus.in_valid    = 1'b1;
    bus.in_dividend = 36'd5;
    bus.abort       = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    bus.abort    = 1'b0;
    chk("idle_abort_busy",     64'(bus.busy), 0);
    chk("idle_abort_in_ready", 64'(bus.in_ready), 1);
    tick;
    chk("idle_abort_still_idle", 64'(bus.busy), 0);

    // reset pulse in the middle of RUN
    bus.in_valid    = 1'b1;
    bus.in_dividend = 36'd12345;
    tick;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("midrst_in_ready",  64'(bus.in_ready), 1);
    chk("midrst_out_valid", 64'(bus.out_valid), 0);
    chk("midrst_busy",      64'(bus.busy), 0);
    chk("midrst_quotient",  64'(bus.out_quotient), 0);
    chk("midrst_remainder", 64'(bus.out_remainder), 0);
    run_op(36'd12345, 1, 1'b0, q, r, acc);
    chk("after_rst_quotient",  64'(q), 51);
    chk("after_rst_remainder", 64'(r), 54);

    // random sweep against x/241, x%241
    for (int n = 0; n < 1500; n++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) tick;
      if ($urandom_range(0, 3) == 0) x = 36'($urandom_range(0, 100000));
      else                           x = {4'($urandom), 32'($urandom)};
      run_op(x, $urandom_range(0, 3), 1'b0, q, r, acc);
      chk("rand_quotient",  64'(q), 64'(x / 36'd241));
      chk("rand_remainder", 64'(r), 64'(x % 36'd241));
      chk("rand_q_top_zero", 64'(q[35:29]), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
